// File: rtl/s27_unroll_ctrl.sv
// Sequencing controller for a FRAMES-deep time-unrolled s27 core: fills an
// input window, waits for the core to settle, then presents G17 and next state.
//
// state | meaning
// FILL  | accepting frame vectors into window slots; st_load honoured at count 0
// EVAL  | window complete, core settling for CORE_LAT+1 cycles, capture on last
// OUT   | result presented until downstream handshake, then state feeds back
module s27_unroll_ctrl #(
  parameter int FRAMES   = 5,
  parameter int CORE_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_vec,
  input  logic                  st_load,
  input  logic [2:0]            st_val,
  output logic [4*FRAMES-1:0]   core_in,
  output logic [2:0]            core_state,
  input  logic [FRAMES-1:0]     core_g17,
  input  logic [2:0]            core_next,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAMES-1:0]     out_g17,
  output logic [2:0]            out_state
);

  localparam int CW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int LW = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAMES - 1);
  localparam logic [LW-1:0] LAT_INIT  = LW'(CORE_LAT);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } fsm_t;

  fsm_t                r_fsm;
  fsm_t                w_fsm_nxt;
  logic [CW-1:0]       r_count;
  logic [LW-1:0]       r_lat;
  logic [4*FRAMES-1:0] r_window;
  logic [2:0]          r_dff;
  logic [FRAMES-1:0]   r_out_g17;
  logic [2:0]          r_out_state;

  logic w_load;
  logic w_accept;
  logic w_last;
  logic w_lat_tc;
  logic w_capture;
  logic w_out_fire;

  assign w_last   = (r_count == LAST_SLOT);
  assign w_lat_tc = (r_lat == '0);

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= FILL;
    else     r_fsm <= w_fsm_nxt;
  end

  // A load request at count 0 stalls input so it can never race a slot-0 write.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_load     = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_out_fire = 1'b0;
    case (r_fsm)
      FILL: begin
        w_load   = st_load && (r_count == '0);
        in_ready = !w_load;
        w_accept = in_valid && !w_load;
        if (w_accept && w_last) w_fsm_nxt = EVAL;
      end
      EVAL: begin
        if (w_lat_tc) begin
          w_capture = 1'b1;
          w_fsm_nxt = OUT;
        end
      end
      OUT: begin
        out_valid  = 1'b1;
        w_out_fire = out_ready;
        if (out_ready) w_fsm_nxt = FILL;
      end
      default: w_fsm_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_lat       <= LAT_INIT;
      r_window    <= '0;
      r_dff       <= '0;
      r_out_g17   <= '0;
      r_out_state <= '0;
    end else begin
      if (w_accept) r_count <= w_last ? '0 : r_count + CW'(1);
      for (int k = 0; k < FRAMES; k++) begin
        if (w_accept && (r_count == CW'(k))) r_window[4*k +: 4] <= in_vec;
      end
      if (w_load)          r_dff <= st_val;
      else if (w_out_fire) r_dff <= r_out_state;
      // settle timer: reloaded when the window completes, counts down in EVAL
      if (w_accept && w_last)             r_lat <= LAT_INIT;
      else if (r_fsm == EVAL && !w_lat_tc) r_lat <= r_lat - LW'(1);
      if (w_capture) begin
        r_out_g17   <= core_g17;
        r_out_state <= core_next;
      end
    end
  end

  assign core_in    = r_window;
  assign core_state = r_dff;
  assign out_g17    = r_out_g17;
  assign out_state  = r_out_state;

  a_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_g17) && $stable(out_state)));

endmodule

// File: tb/tb_s27_unroll_ctrl.sv
// Bench for s27_unroll_ctrl: behavioural s27 core stub plus a transaction-level
// reference model (accepted-vector queue, result timestamp) checked every cycle.
module tb_s27_unroll_ctrl;
  localparam int FRAMES = 5;
  localparam int LAT    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [3:0]          in_vec = '0;
  logic                st_load = 1'b0;
  logic [2:0]          st_val = '0;
  logic [4*FRAMES-1:0] core_in;
  logic [2:0]          core_state;
  logic [FRAMES-1:0]   core_g17;
  logic [2:0]          core_next;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [FRAMES-1:0]   out_g17;
  logic [2:0]          out_state;

  s27_unroll_ctrl #(.FRAMES(FRAMES), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .st_load(st_load), .st_val(st_val),
    .core_in(core_in), .core_state(core_state),
    .core_g17(core_g17), .core_next(core_next),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_g17(out_g17), .out_state(out_state)
  );

  always #5 clk = ~clk;

  // s27 netlist evaluated frame by frame; returns {final_state, g17_vector}
  function automatic logic [FRAMES+2:0] s27_run(input logic [2:0] s0,
                                                 input logic [4*FRAMES-1:0] w);
    logic [2:0] s;
    logic [FRAMES-1:0] g;
    logic [3:0] v;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    s = s0;
    g = '0;
    for (int k = 0; k < FRAMES; k++) begin
      v   = w[4*k +: 4];
      g14 = ~v[0];
      g8  = g14 & s[1];
      g12 = ~(v[1] | s[2]);
      g15 = g12 | g8;
      g16 = v[3] | g8;
      g9  = ~(g16 & g15);
      g11 = ~(s[0] | g9);
      g10 = ~(g14 | g11);
      g13 = ~(v[2] | g12);
      g[k] = ~g11;
      s   = {g13, g11, g10};
    end
    return {s, g};
  endfunction

  assign {core_next, core_g17} = s27_run(core_state, core_in);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [3:0]          m_q[$];
  logic [4*FRAMES-1:0] m_win = '0;
  logic [2:0]          m_st = '0;
  logic                m_pend = 1'b0;
  int                  m_ready_at = 0;
  logic [FRAMES+2:0]   m_res = '0;
  logic [FRAMES+2:0]   m_shown = '0;
  int                  cyc = 0;

  task automatic step(input logic r, input logic iv, input logic [3:0] vec,
                      input logic sl, input logic [2:0] sv, input logic orr);
    logic exp_ir, exp_ov;
    logic [FRAMES+2:0] exp_out;
    logic [4*FRAMES-1:0] tmp;
    @(negedge clk);
    rst = r; in_valid = iv; in_vec = vec; st_load = sl; st_val = sv; out_ready = orr;
    #1;
    exp_ov  = m_pend && (cyc >= m_ready_at);
    exp_ir  = !m_pend && !(sl && m_q.size() == 0);
    exp_out = exp_ov ? m_res : m_shown;
    chk("in_ready",   32'(in_ready),   32'(exp_ir));
    chk("out_valid",  32'(out_valid),  32'(exp_ov));
    chk("out_g17",    32'(out_g17),    32'(exp_out[FRAMES-1:0]));
    chk("out_state",  32'(out_state),  32'(exp_out[FRAMES+2:FRAMES]));
    chk("core_state", 32'(core_state), 32'(m_st));
    chk("core_in",    32'(core_in),    32'(m_win));
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_win = '0; m_st = '0; m_pend = 1'b0; m_shown = '0;
    end else if (!m_pend) begin
      if (sl && m_q.size() == 0) m_st = sv;
      else if (iv) begin
        m_win[4*m_q.size() +: 4] = vec;
        m_q.push_back(vec);
        if (m_q.size() == FRAMES) begin
          for (int k = 0; k < FRAMES; k++) tmp[4*k +: 4] = m_q[k];
          m_res = s27_run(m_st, tmp);
          m_pend = 1'b1;
          m_ready_at = cyc + LAT + 2;
          m_q.delete();
        end
      end
    end else if (exp_ov && orr) begin
      m_st = m_res[FRAMES+2:FRAMES];
      m_shown = m_res;
      m_pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic orr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 3'b000, orr);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_in",   32'(core_in),   32'd0);
    chk("rst_out_g17",   32'(out_g17),   32'd0);

    // all-zero window from state 000, latency check
    for (int i = 0; i < FRAMES; i++) step(1'b0, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0);
    #1 chk("lat_early0", 32'(out_valid), 32'd0);
    idle(LAT, 1'b0);
    #1 chk("lat_early1", 32'(out_valid), 32'd0);
    idle(1, 1'b0);
    #1 chk("lat_rise",   32'(out_valid), 32'd1);
    chk("zero_g17",   32'(out_g17),   32'h1f);
    chk("zero_state", 32'(out_state), 32'd0);
    idle(1, 1'b1);
    #1 chk("hs_drop", 32'(out_valid), 32'd0);

    // G3=1 window
    for (int i = 0; i < FRAMES; i++) step(1'b0, 1'b1, 4'h8, 1'b0, 3'b000, 1'b0);
    idle(LAT + 1, 1'b0);
    #1 chk("g3_g17",   32'(out_g17),   32'd0);
    chk("g3_state", 32'(out_state), 32'd2);
    idle(1, 1'b1);
    #1 chk("g3_feedback", 32'(core_state), 32'd2);

    // load with simultaneous valid at count 0
    step(1'b0, 1'b1, 4'h6, 1'b1, 3'b101, 1'b0);
    #1 chk("load_state", 32'(core_state), 32'd5);
    step(1'b0, 1'b1, 4'h6, 1'b0, 3'b000, 1'b0);
    #1 chk("load_slot0", 32'(core_in[3:0]), 32'h6);

    // load ignored at count 2
    step(1'b0, 1'b1, 4'h3, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1, 3'b111, 1'b0);
    #1 chk("load_ignored", 32'(core_state), 32'd5);

    // reset mid-window
    step(1'b0, 1'b1, 4'h9, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 4'hf, 1'b0, 3'b000, 1'b1);
    #1 chk("mid_rst_core_in", 32'(core_in),    32'd0);
    chk("mid_rst_state",   32'(core_state), 32'd0);
    chk("mid_rst_ready",   32'(in_ready),   32'd1);
    for (int i = 0; i < FRAMES; i++) step(1'b0, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0);
    idle(LAT + 1, 1'b0);
    #1 chk("post_rst_g17", 32'(out_g17), 32'h1f);
    idle(1, 1'b1);

    // backpressure in OUT, then back-to-back into slot 0
    for (int i = 0; i < FRAMES; i++)
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 3'b000, 1'b0);
    idle(LAT + 1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h5, 1'b0, 3'b000, 1'b0);
    #1 chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 4'h4, 1'b0, 3'b000, 1'b1);
    step(1'b0, 1'b1, 4'ha, 1'b0, 3'b000, 1'b0);
    #1 chk("b2b_slot0", 32'(core_in[3:0]), 32'ha);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
